// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the I2C bridge command path: command codes, command-word and
// status-word bit positions, and the arbiter state encoding.
package i2c_bridge_pkg;

  typedef enum logic [3:0] {
    CmdNop        = 4'h0,
    CmdRead       = 4'h1,
    CmdWrite      = 4'h2,
    CmdWriteMulti = 4'h3,
    CmdStart      = 4'h4,
    CmdStop       = 4'h5,
    CmdSetAddr    = 4'hB,
    CmdSetSclL    = 4'hC,
    CmdSetSclH    = 4'hD,
    CmdStopOnIdle = 4'hE,
    CmdReset      = 4'hF
  } i2c_cmd_e;

  localparam int unsigned FlagLastBit    = 12;
  localparam int unsigned StatInProgBit  = 0;
  localparam int unsigned StatBusBusyBit = 2;

  // Command word the arbiter issues on its own when a lock owner goes silent.
  localparam logic [15:0] AbortStopWord = 16'h0500;

  typedef enum logic [3:0] {
    StIdle,
    StIssue,
    StGap,
    StPoll,
    StRespond,
    StLocked,
    StAbort,
    StAbortGap,
    StAbortPoll
  } arb_state_e;

  function automatic logic cmd_takes_lock(input logic [15:0] word);
    return (word[11:8] == CmdStart) || (word[11:8] == CmdSetAddr);
  endfunction

  function automatic logic cmd_releases_lock(input logic [15:0] word);
    return (word[11:8] == CmdStop) || (word[11:8] == CmdReset) || word[FlagLastBit];
  endfunction

endpackage

// File: rtl/i2c_status_poller.sv
// Gap timer and busy check shared by the normal and abort poll loops of the arbiter.
module i2c_status_poller
  import i2c_bridge_pkg::*;
#(
  parameter int unsigned POLL_GAP = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic gap_i,
  input  logic poll_i,
  input  logic br_ack_i,
  input  logic in_prog_i,
  output logic gap_done_o,
  output logic poll_busy_o,
  output logic poll_done_o
);

  localparam int unsigned CntW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    gap_done_o  = gap_i && (cnt_q == CntW'(POLL_GAP - 1));
    cnt_d       = (gap_i && !gap_done_o) ? cnt_q + CntW'(1) : '0;
    poll_busy_o = poll_i && br_ack_i && in_prog_i;
    poll_done_o = poll_i && br_ack_i && !in_prog_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Two-requester arbiter in front of the I2C bridge: round-robin grant, command issue,
// status polling, bus locking across START/SET_ADDR and a timeout abort for silent owners.
module i2c_cmd_arbiter
  import i2c_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned POLL_GAP       = 8
) (
  input  logic        sysclk,
  input  logic        n_reset,
  input  logic        r0_req,
  input  logic [15:0] r0_d,
  output logic        r0_ack,
  output logic [15:0] r0_q,
  input  logic        r1_req,
  input  logic [15:0] r1_d,
  output logic        r1_ack,
  output logic [15:0] r1_q,
  output logic        br_req,
  output logic        br_wr,
  output logic        br_sel,
  output logic [15:0] br_d,
  input  logic [15:0] br_q,
  input  logic        br_ack,
  output logic [1:0]  locked_owner
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;   // 0 = r0, 1 = r1
  logic            rr_q, rr_d;         // requester favoured on a tie
  logic [1:0]      lock_q, lock_d;
  logic [15:0]     cmd_q, cmd_d;
  logic [15:0]     status_q, status_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic        gap, poll, gap_done, poll_busy, poll_done;
  logic        grant, owner_req;
  logic [15:0] owner_cmd;

  i2c_status_poller #(
    .POLL_GAP(POLL_GAP)
  ) u_poller (
    .clk_i      (sysclk),
    .rst_ni     (n_reset),
    .gap_i      (gap),
    .poll_i     (poll),
    .br_ack_i   (br_ack),
    .in_prog_i  (br_q[StatInProgBit]),
    .gap_done_o (gap_done),
    .poll_busy_o(poll_busy),
    .poll_done_o(poll_done)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    cmd_d     = cmd_q;
    status_d  = status_q;
    tmo_d     = tmo_q;
    br_req    = 1'b0;
    br_wr     = 1'b0;
    br_sel    = 1'b0;
    gap       = 1'b0;
    poll      = 1'b0;
    r0_ack    = 1'b0;
    r1_ack    = 1'b0;
    grant     = 1'b0;
    owner_req = owner_q ? r1_req : r0_req;
    owner_cmd = owner_q ? r1_d : r0_d;

    unique case (state_q)
      StIdle: begin
        if (r0_req || r1_req) begin
          grant   = (r0_req && r1_req) ? rr_q : r1_req;
          owner_d = grant;
          cmd_d   = grant ? r1_d : r0_d;
          state_d = StIssue;
        end
      end
      StIssue: begin
        br_req = 1'b1;
        br_wr  = 1'b1;
        if (br_ack) state_d = StGap;
      end
      StGap: begin
        gap = 1'b1;
        if (gap_done) state_d = StPoll;
      end
      StPoll: begin
        br_req = 1'b1;
        br_sel = 1'b1;
        poll   = 1'b1;
        if (poll_busy) begin
          state_d = StGap;
        end else if (poll_done) begin
          status_d = br_q;
          state_d  = StRespond;
        end
      end
      StRespond: begin
        r0_ack = !owner_q;
        r1_ack = owner_q;
        rr_d   = !owner_q;
        // Release wins over acquire when a word carries both.
        if (cmd_releases_lock(cmd_q)) begin
          lock_d  = 2'b00;
          state_d = StIdle;
        end else if (cmd_takes_lock(cmd_q) || (lock_q != 2'b00)) begin
          lock_d  = owner_q ? 2'b10 : 2'b01;
          tmo_d   = '0;
          state_d = StLocked;
        end else begin
          state_d = StIdle;
        end
      end
      StLocked: begin
        if (owner_req) begin
          cmd_d   = owner_cmd;
          tmo_d   = '0;
          state_d = StIssue;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          cmd_d   = AbortStopWord;
          tmo_d   = '0;
          state_d = StAbort;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StAbort: begin
        br_req = 1'b1;
        br_wr  = 1'b1;
        if (br_ack) state_d = StAbortGap;
      end
      StAbortGap: begin
        gap = 1'b1;
        if (gap_done) state_d = StAbortPoll;
      end
      StAbortPoll: begin
        br_req = 1'b1;
        br_sel = 1'b1;
        poll   = 1'b1;
        if (poll_busy) begin
          state_d = StAbortGap;
        end else if (poll_done) begin
          lock_d  = 2'b00;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign br_d         = cmd_q;
  assign r0_q         = r0_ack ? status_q : 16'h0000;
  assign r1_q         = r1_ack ? status_q : 16'h0000;
  assign locked_owner = lock_q;

  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      lock_q   <= 2'b00;
      cmd_q    <= 16'h0000;
      status_q <= 16'h0000;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      lock_q   <= lock_d;
      cmd_q    <= cmd_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter with a simple bridge model that echoes the last
// written data byte in the final status word.
module tb_i2c_cmd_arbiter;

  logic        sysclk;
  logic        n_reset;
  logic        r0_req, r1_req;
  logic [15:0] r0_d, r1_d;
  logic        r0_ack, r1_ack;
  logic [15:0] r0_q, r1_q;
  logic        br_req, br_wr, br_sel;
  logic [15:0] br_d;
  logic [15:0] br_q;
  logic        br_ack;
  logic [1:0]  locked_owner;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic        port;
    logic [15:0] q;
  } exp_t;

  exp_t exp_q[$];

  // Bridge model state.
  int          rd_total;
  int          rd_mark;
  int          busy_cfg;
  int          wr_total;
  logic [15:0] last_wr;

  i2c_cmd_arbiter dut (
    .sysclk      (sysclk),
    .n_reset     (n_reset),
    .r0_req      (r0_req),
    .r0_d        (r0_d),
    .r0_ack      (r0_ack),
    .r0_q        (r0_q),
    .r1_req      (r1_req),
    .r1_d        (r1_d),
    .r1_ack      (r1_ack),
    .r1_q        (r1_q),
    .br_req      (br_req),
    .br_wr       (br_wr),
    .br_sel      (br_sel),
    .br_d        (br_d),
    .br_q        (br_q),
    .br_ack      (br_ack),
    .locked_owner(locked_owner)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Bridge: one-cycle ack a cycle after each request; status busy for busy_cfg reads.
  always @(posedge sysclk) begin
    br_ack <= 1'b0;
    if (br_req && !br_ack) begin
      br_ack <= 1'b1;
      if (br_wr) begin
        last_wr  <= br_d;
        wr_total <= wr_total + 1;
      end else begin
        if (rd_total - rd_mark < busy_cfg) br_q <= 16'h0005;
        else                               br_q <= {last_wr[7:0], 8'h40};
        rd_total <= rd_total + 1;
      end
    end
  end

  // Monitor: every ack must match the head of the scoreboard.
  always @(negedge sysclk) begin
    if (r0_ack || r1_ack) begin
      exp_t e;
      n_checks++;
      if (r0_ack && r1_ack) begin
        n_errors++;
        $display("FAIL ack_both: r0_ack=1 r1_ack=1, required a single ack");
      end else if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL ack_unexpected: r0_ack=%0b r1_ack=%0b r0_q=%h r1_q=%h, required no ack",
                 r0_ack, r1_ack, r0_q, r1_q);
      end else begin
        e = exp_q.pop_front();
        if ({r1_ack, (r1_ack ? r1_q : r0_q), (r1_ack ? r0_q : r1_q)} !== {e.port, e.q, 16'h0000})
        begin
          n_errors++;
          $display("FAIL ack_resp: got port r%0d q=%h other_q=%h, required port r%0d q=%h other_q=0000",
                   r1_ack, (r1_ack ? r1_q : r0_q), (r1_ack ? r0_q : r1_q), e.port, e.q);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic expect_ack(input logic port, input logic [15:0] d);
    exp_t e;
    e.port = port;
    e.q    = {d[7:0], 8'h40};
    exp_q.push_back(e);
  endtask

  // Raise the selected requests and drop each one on its ack, within a cycle budget.
  task automatic run_reqs(input bit w0, input bit w1, input logic [15:0] d0,
                          input logic [15:0] d1, input int busy);
    bit p0, p1;
    int n;
    rd_mark  = rd_total;
    busy_cfg = busy;
    p0 = w0;
    p1 = w1;
    if (w0) begin r0_d = d0; r0_req = 1'b1; end
    if (w1) begin r1_d = d1; r1_req = 1'b1; end
    n = 0;
    while ((p0 || p1) && n < 2000) begin
      @(negedge sysclk);
      n++;
      if (p0 && r0_ack) begin r0_req = 1'b0; p0 = 1'b0; end
      if (p1 && r1_ack) begin r1_req = 1'b0; p1 = 1'b0; end
    end
    n_checks++;
    if (p0 || p1) begin
      n_errors++;
      $display("FAIL ack_wait: pending r0=%0b r1=%0b after %0d cycles, required both acked",
               p0, p1, n);
      r0_req = 1'b0;
      r1_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int wr_mark;
    int rd_before;
    n_checks = 0;
    n_errors = 0;
    rd_total = 0;
    rd_mark  = 0;
    busy_cfg = 0;
    wr_total = 0;
    last_wr  = 16'h0000;
    br_q     = 16'h0000;
    br_ack   = 1'b0;
    r0_req   = 1'b0;
    r1_req   = 1'b0;
    r0_d     = 16'h0000;
    r1_d     = 16'h0000;
    n_reset  = 1'b1;

    // Reset state.
    #2 n_reset = 1'b0;
    #1;
    check("rst_bridge", {45'd0, br_req, br_wr, br_sel, br_d}, 64'd0);
    check("rst_acks", {30'd0, r0_ack, r1_ack, r0_q, r1_q}, 64'd0);
    check("rst_lock", {62'd0, locked_owner}, 64'd0);
    repeat (3) @(negedge sysclk);
    n_reset = 1'b1;
    repeat (2) @(negedge sysclk);

    // Simultaneous requests: r0 first, then r1; alone r0; then a tie goes to r1.
    expect_ack(1'b0, 16'h0211);
    expect_ack(1'b1, 16'h0222);
    run_reqs(1'b1, 1'b1, 16'h0211, 16'h0222, 0);
    expect_ack(1'b0, 16'h0133);
    run_reqs(1'b1, 1'b0, 16'h0133, 16'h0000, 1);
    expect_ack(1'b1, 16'h0255);
    expect_ack(1'b0, 16'h0244);
    run_reqs(1'b1, 1'b1, 16'h0244, 16'h0255, 0);
    @(negedge sysclk);
    check("rr_no_lock", {62'd0, locked_owner}, 64'd0);

    // SET_ADDR with three busy polls takes the lock for r0.
    rd_before = rd_total;
    expect_ack(1'b0, 16'h0B72);
    run_reqs(1'b1, 1'b0, 16'h0B72, 16'h0000, 3);
    check("lock_reads", 64'(rd_total - rd_before), 64'd4);
    repeat (2) @(negedge sysclk);
    check("lock_r0", {62'd0, locked_owner}, 64'd1);

    // r1 blocked while r0 holds the lock; r0's last-byte command releases it.
    r1_d   = 16'h031E;
    r1_req = 1'b1;
    repeat (30) @(negedge sysclk);
    check("lock_hold", {62'd0, locked_owner}, 64'd1);
    check("lock_no_issue", {63'd0, br_req}, 64'd0);
    expect_ack(1'b0, 16'h1327);
    expect_ack(1'b1, 16'h031E);
    run_reqs(1'b1, 1'b1, 16'h1327, 16'h031E, 0);
    repeat (2) @(negedge sysclk);
    check("lock_released", {62'd0, locked_owner}, 64'd0);

    // r1 locks and goes silent: the arbiter issues STOP without any ack.
    expect_ack(1'b1, 16'h0B72);
    run_reqs(1'b0, 1'b1, 16'h0000, 16'h0B72, 0);
    wr_mark = wr_total;
    @(negedge sysclk);
    check("lock_r1", {62'd0, locked_owner}, 64'd2);
    waited = 1;
    while (locked_owner != 2'b00 && waited < 5000) begin
      @(negedge sysclk);
      waited++;
    end
    check("tmo_window", {63'd0, (waited >= 4096 && waited < 4150)}, 64'd1);
    check("tmo_stop_word", {48'd0, last_wr}, 64'h0500);
    check("tmo_writes", 64'(wr_total - wr_mark), 64'd1);
    repeat (5) @(negedge sysclk);
    check("tmo_lock_clear", {62'd0, locked_owner}, 64'd0);

    // Reset during a status poll abandons the transaction.
    rd_mark  = rd_total;
    busy_cfg = 5;
    r0_d     = 16'h0266;
    r0_req   = 1'b1;
    waited   = 0;
    while (!(br_req && br_sel) && waited < 100) begin
      @(negedge sysclk);
      waited++;
    end
    check("poll_reached", {63'd0, (br_req && br_sel)}, 64'd1);
    n_reset = 1'b0;
    #1;
    check("rst_poll_brreq", {63'd0, br_req}, 64'd0);
    check("rst_poll_outs", {30'd0, r0_ack, r1_ack, locked_owner, br_d}, 64'd0);
    r0_req = 1'b0;
    repeat (3) @(negedge sysclk);
    n_reset = 1'b1;
    repeat (40) @(negedge sysclk);
    check("rst_poll_idle", {63'd0, br_req}, 64'd0);
    expect_ack(1'b0, 16'h0203);
    run_reqs(1'b1, 1'b0, 16'h0203, 16'h0000, 1);
    repeat (5) @(negedge sysclk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
